// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: FSM state encoding and
// datapath widths used by the capture stage and its history buffer.
package alu_pkg;

  localparam int unsigned RES_W = 8;  // ALU result width
  localparam int unsigned NIB_W = 4;  // operand B (low nibble) width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

endpackage

// File: rtl/alu_hist_buf.sv
// Circular history of captured ALU results.
// Ports:
//   clock, reset   - clock, async active-high reset (clears memory too)
//   wr_en, din     - write din at the write pointer and advance it
//   view_sel       - history index, 0 = most recent
//   hist_out       - selected entry (combinational), 0 when index >= count
//   count          - number of valid entries, saturates at DEPTH
module alu_hist_buf
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [RES_W-1:0]           din,
  input  logic [$clog2(DEPTH)-1:0]   view_sel,
  output logic [RES_W-1:0]           hist_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [RES_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_idx;

  // Storage, write pointer and saturating occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
      wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end
  end

  // Newest entry sits just behind the write pointer; pointer math wraps
  // naturally because DEPTH is a power of two.
  always_comb begin
    rd_idx   = wr_ptr_q - PTR_W'(1) - view_sel;
    hist_out = ({1'b0, view_sel} < count_q) ? mem_q[rd_idx] : '0;
  end

  assign count = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after alu_cpu. One capture of alu_out per exec
// press; the captured low nibble is fed back as operand B, and every
// capture is also logged into a small circular history.
// Ports:
//   clock, reset   - clock, async active-high reset
//   exec           - asynchronous capture request (synchronized here)
//   clear          - synchronous; zeroes result/b_feedback/ovf, not history
//   alu_out        - ALU result to capture
//   view_sel       - history index, 0 = most recent
//   b_feedback     - captured low nibble, operand B to the ALU
//   result, ovf    - captured result and its upper-nibble-nonzero flag
//   done           - one-cycle pulse after each capture
//   hist_out,count - selected history entry and number of valid entries
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       exec,
  input  logic                       clear,
  input  logic [RES_W-1:0]           alu_out,
  input  logic [$clog2(DEPTH)-1:0]   view_sel,
  output logic [NIB_W-1:0]           b_feedback,
  output logic [RES_W-1:0]           result,
  output logic                       ovf,
  output logic                       done,
  output logic [RES_W-1:0]           hist_out,
  output logic [$clog2(DEPTH):0]     count
);

  logic             exec_meta_q, exec_s_q;
  state_e           state_q, state_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [NIB_W-1:0] b_q, b_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             wr_en;

  // Two-flop synchronizer for the button-derived exec.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exec_meta_q <= 1'b0;
      exec_s_q    <= 1'b0;
    end else begin
      exec_meta_q <= exec;
      exec_s_q    <= exec_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      b_q      <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      b_q      <= b_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Next state and register updates; clear overrides a capture.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    b_d      = b_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: if (exec_s_q) state_d = CAPTURE;
      CAPTURE: begin
        state_d = WAIT_REL;
        if (!clear) begin
          result_d = alu_out;
          b_d      = alu_out[NIB_W-1:0];
          ovf_d    = |alu_out[RES_W-1:NIB_W];
          done_d   = 1'b1;
          wr_en    = 1'b1;
        end
      end
      WAIT_REL: if (!exec_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      result_d = '0;
      b_d      = '0;
      ovf_d    = 1'b0;
    end
  end

  alu_hist_buf #(.DEPTH(DEPTH)) u_hist (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .din      (alu_out),
    .view_sel (view_sel),
    .hist_out (hist_out),
    .count    (count)
  );

  assign result     = result_q;
  assign b_feedback = b_q;
  assign ovf        = ovf_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       exec;
  logic       clear;
  logic [7:0] alu_out;
  logic [1:0] view_sel;
  logic [3:0] b_feedback;
  logic [7:0] result;
  logic       ovf;
  logic       done;
  logic [7:0] hist_out;
  logic [2:0] count;

  logic       acc_mode;
  logic [7:0] alu_drv;
  int         n_cmp = 0;
  int         n_err = 0;

  // alu_cpu stand-in: mode 1 (A+B) with A=3 when acc_mode, else a direct drive.
  assign alu_out = acc_mode ? (8'h03 + {4'h0, b_feedback}) : alu_drv;

  always #5 clock = ~clock;

  alu_result_stage #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .exec(exec), .clear(clear),
    .alu_out(alu_out), .view_sel(view_sel), .b_feedback(b_feedback),
    .result(result), .ovf(ovf), .done(done), .hist_out(hist_out),
    .count(count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; exec = 1'b0; clear = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Press exec for 5 cycles, then release long enough to re-arm.
  task automatic press(input logic [7:0] d);
    @(negedge clock);
    alu_drv = d; exec = 1'b1;
    repeat (5) @(negedge clock);
    exec = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result got %h want 00", result); end
    n_cmp++; if (b_feedback !== 4'h0) begin n_err++; $display("FAIL reset_b got %h want 0", b_feedback); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      n_cmp++; if (hist_out !== 8'h00) begin n_err++; $display("FAIL reset_hist[%0d] got %h want 00", v, hist_out); end
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    alu_drv = 8'h3C; exec = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (done !== (i == 3)) begin n_err++; $display("FAIL single_done_cyc%0d got %b want %b", i, done, (i == 3)); end
      if (i == 3) begin
        n_cmp++; if (result !== 8'h3C) begin n_err++; $display("FAIL single_result got %h want 3c", result); end
        n_cmp++; if (b_feedback !== 4'hC) begin n_err++; $display("FAIL single_b got %h want c", b_feedback); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL single_ovf got %b want 1", ovf); end
      end
      if (i == 4) begin
        @(negedge clock);
        exec = 1'b0;
      end
    end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_seq [4];
    logic [7:0] exp_hist [4];
    exp_seq  = '{8'h03, 8'h06, 8'h09, 8'h0C};
    exp_hist = '{8'h0C, 8'h09, 8'h06, 8'h03};
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    n_cmp++; if (b_feedback !== 4'h0) begin n_err++; $display("FAIL clear_idle_b got %h want 0", b_feedback); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL clear_idle_result got %h want 00", result); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL clear_idle_count got %0d want 1", count); end
    acc_mode = 1'b1;
    for (int p = 0; p < 4; p++) begin
      press(8'h00);
      n_cmp++; if (result !== exp_seq[p]) begin n_err++; $display("FAIL acc_result[%0d] got %h want %h", p, result, exp_seq[p]); end
    end
    acc_mode = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL acc_count got %0d want 4", count); end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      n_cmp++; if (hist_out !== exp_hist[v]) begin n_err++; $display("FAIL acc_hist[%0d] got %h want %h", v, hist_out, exp_hist[v]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    alu_drv = 8'h77; exec = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (dut.state_q !== CAPTURE) begin n_err++; $display("FAIL rstmid_pre_state got %0d want 1", dut.state_q); end
    #2;
    reset = 1'b1; exec = 1'b0;
    #1;
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL rstmid_result got %h want 00", result); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", count); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
    n_cmp++; if (b_feedback !== 4'h0) begin n_err++; $display("FAIL rstmid_b got %h want 0", b_feedback); end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      n_cmp++; if (hist_out !== 8'h00) begin n_err++; $display("FAIL rstmid_hist[%0d] got %h want 00", v, hist_out); end
    end
    @(negedge clock); reset = 1'b0;
    repeat (4) tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_lost_count got %0d want 0", count); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL rstmid_lost_result got %h want 00", result); end
  endtask

  task automatic test_partial();
    logic [7:0] exp_hist [4];
    exp_hist = '{8'hB2, 8'hA1, 8'h00, 8'h00};
    apply_reset();
    press(8'hA1);
    press(8'hB2);
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL partial_count got %0d want 2", count); end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      n_cmp++; if (hist_out !== exp_hist[v]) begin n_err++; $display("FAIL partial_hist[%0d] got %h want %h", v, hist_out, exp_hist[v]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_hist [4];
    exp_hist = '{8'h06, 8'h05, 8'h04, 8'h03};
    apply_reset();
    for (int d = 1; d <= 6; d++) press(8'(d));
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL wrap_count got %0d want 4", count); end
    n_cmp++; if (result !== 8'h06) begin n_err++; $display("FAIL wrap_result got %h want 06", result); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got %b want 0", ovf); end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      n_cmp++; if (hist_out !== exp_hist[v]) begin n_err++; $display("FAIL wrap_hist[%0d] got %h want %h", v, hist_out, exp_hist[v]); end
    end
  endtask

  task automatic test_clear_collision();
    view_sel = 2'd0;
    @(negedge clock);
    alu_drv = 8'hFF; exec = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); clear = 1'b1;
    tick();
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL coll_result got %h want 00", result); end
    n_cmp++; if (b_feedback !== 4'h0) begin n_err++; $display("FAIL coll_b got %h want 0", b_feedback); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL coll_ovf got %b want 0", ovf); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL coll_done got %b want 0", done); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL coll_count got %0d want 4", count); end
    n_cmp++; if (hist_out !== 8'h06) begin n_err++; $display("FAIL coll_hist0 got %h want 06", hist_out); end
    n_cmp++; if (dut.state_q !== WAIT_REL) begin n_err++; $display("FAIL coll_state got %0d want 2", dut.state_q); end
    @(negedge clock); clear = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL coll_late_done got %b want 0", done); end
    @(negedge clock); exec = 1'b0;
    repeat (4) tick();
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL coll_final_count got %0d want 4", count); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL coll_final_result got %h want 00", result); end
  endtask

  initial begin
    reset = 1'b1; exec = 1'b0; clear = 1'b0;
    view_sel = 2'd0; acc_mode = 1'b0; alu_drv = 8'h00;
    test_reset();
    test_single();
    test_accumulate();
    test_reset_mid();
    test_partial();
    test_wrap();
    test_clear_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
